reg_ring_master: RTL and testbench
==================================

Name: reg_ring_master

Overview:
- Initiator end of the UDP register ring. It converts single register commands from a local client into ring transactions.
- Typical clients are a test sequencer or a self-loader that programs the pipeline control/imem/dmem registers without the host.
- It sits at the head of the ring. It drives the reg_*_out chain into the first responder (e.g. a generic_regs-based block) and receives the returning transaction on reg_*_in from the ring tail.
- It returns read data and completion status to the client through a valid/ready response port.

Parameters:
- ADDR_WIDTH, 23, ring address width.
- DATA_WIDTH, 32, ring data width.
- UDP_REG_SRC_WIDTH, 2, width of the source tag.
- SRC_ID, 2'd3, source tag this master stamps on its requests and matches on returns.
- TIMEOUT_CYCLES, 1024, cycles to wait for a return before declaring timeout (min 2).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  client command valid.
- cmd_ready  out  1  master can accept a command.
- cmd_rd_wr_L  in  1  1 = read, 0 = write.
- cmd_addr  in  ADDR_WIDTH  register address.
- cmd_wdata  in  DATA_WIDTH  write data (ignored on read).
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  client accepts response.
- rsp_rdata  out  DATA_WIDTH  data returned by the ring.
- rsp_status  out  2  0 = OK, 1 = NACK (no responder acked), 2 = TIMEOUT.
- reg_req_out  out  1  ring request pulse.
- reg_ack_out  out  1  always 0 on issued requests.
- reg_rd_wr_L_out  out  1  ring read/write.
- reg_addr_out  out  ADDR_WIDTH  ring address.
- reg_data_out  out  DATA_WIDTH  ring data.
- reg_src_out  out  UDP_REG_SRC_WIDTH  ring source.
- reg_req_in  in  1  returning request.
- reg_ack_in  in  1  returning ack.
- reg_rd_wr_L_in  in  1  returning read/write flag (unused except for debug).
- reg_addr_in  in  ADDR_WIDTH  returning address (unused except for debug).
- reg_data_in  in  DATA_WIDTH  returning data.
- reg_src_in  in  UDP_REG_SRC_WIDTH  returning source.
- stray_cnt  out  8  count of discarded unexpected returns, saturating.

Behaviour:
- Reset values:
  - State = IDLE, cmd_ready = 1.
  - rsp_valid = 0, rsp_rdata = 0, rsp_status = 0.
  - All reg_*_out = 0, stray_cnt = 0.
  - Timeout counter = 0.
- All outputs are registered. There is one outstanding transaction at a time.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid & cmd_ready, latch rd_wr_L, addr and wdata. Go to ISSUE.
- ISSUE, exactly one cycle:
  - reg_req_out = 1, reg_ack_out = 0.
  - reg_rd_wr_L_out = latched rd_wr_L, reg_addr_out = latched addr.
  - reg_data_out = latched wdata on write, 0 on read.
  - reg_src_out = SRC_ID.
  - Clear the timeout counter. Go to WAIT.
  - The request is visible on the ring in the cycle after the command handshake.
- Outside ISSUE, reg_req_out = 0 and the other reg_*_out hold 0.
- WAIT:
  - Increment the timeout counter each cycle.
  - If reg_req_in & reg_src_in == SRC_ID:
    - rsp_rdata = reg_data_in.
    - rsp_status = 0 if reg_ack_in, else 1.
    - Go to RESP.
  - Else, if counter == TIMEOUT_CYCLES-1: rsp_rdata = 0, rsp_status = 2, go to RESP.
  - A matching return in the same cycle as the timeout expiry wins: status is OK/NACK, not TIMEOUT.
- RESP:
  - rsp_valid = 1, with rsp_* held stable.
  - On rsp_ready, drop rsp_valid and go to IDLE. cmd_ready rises in the next cycle.
  - If rsp_ready is already high on RESP entry, the response completes in one cycle.
- Write responses also carry the returned reg_data_in in rsp_rdata; clients ignore it.
- Stray returns:
  - A stray is reg_req_in with matching src outside WAIT (e.g. a late return after a timeout), or any reg_req_in with non-matching src.
  - Strays are discarded and increment stray_cnt, which saturates at 255.
- A non-matching return during WAIT does not complete the transaction.
- Reset mid-transaction returns everything to reset values. Any later return of the aborted request is counted as a stray.
- cmd_* inputs are ignored while cmd_ready = 0.

Decomposition:
- Shared package (reg_ring_pkg) holds:
  - Status codes RSP_OK = 2'd0, RSP_NACK = 2'd1, RSP_TIMEOUT = 2'd2.
  - FSM state encodings.
  - The UDP_REG_ADDR_WIDTH and CPCI_NF2_DATA_WIDTH defaults.
- No sub-module is needed. The timeout counter and stray counter are inline.

Test Plan:
- Write hit:
  - Stimulus: cmd write addr=0x000101, wdata=0xDEADBEEF. A loopback responder acks after 3 cycles.
  - Required response: reg_req_out is a 1-cycle pulse one cycle after the handshake, with src=3, ack_out=0 and the correct addr/data.
  - rsp_status = 0. cmd_ready is low from the accept cycle until the cycle after rsp handshake.
- Read hit:
  - Stimulus: cmd read addr=0x000100. The responder returns data 0x000001A5 with ack=1.
  - Required response: reg_data_out = 0 on issue. rsp_rdata = 0x000001A5, rsp_status = 0.
- NACK:
  - Stimulus: the ring returns the request unchanged (ack=0).
  - Required response: rsp_status = 1, rsp_rdata = the returned data.
- Timeout and late return:
  - Stimulus: TIMEOUT_CYCLES = 16 with no return. Then inject the matching return 5 cycles later while IDLE.
  - Required response: rsp_status = 2 exactly 16 cycles after issue. stray_cnt = 1, and no spurious rsp_valid.
- Backpressure / foreign src:
  - Stimulus: hold rsp_ready = 0 for 10 cycles, and inject a return with src=1 during WAIT.
  - Required response: rsp_* stay stable and no new command is accepted. The foreign return does not complete the transaction and stray_cnt increments.
- Reset mid-WAIT:
  - Stimulus: assert reset for 1 cycle during WAIT.
  - Required response: all outputs return to reset values and cmd_ready = 1 the next cycle.

Source files
------------

// File: rtl/reg_ring_pkg.sv
// Shared definitions for the register ring master.
//   - default ring address/data widths
//   - response status codes returned to the client
//   - FSM state encoding of the master
package reg_ring_pkg;

   localparam int UDP_REG_ADDR_WIDTH  = 23;
   localparam int CPCI_NF2_DATA_WIDTH = 32;

   localparam logic [1:0] RSP_OK      = 2'd0;
   localparam logic [1:0] RSP_NACK    = 2'd1;
   localparam logic [1:0] RSP_TIMEOUT = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

endpackage

// File: rtl/reg_ring_master_if.sv
// Bundle of the client command/response handshake and the register ring
// in/out chain seen by the ring master.
//   master modport : the ring master (drives cmd_ready, rsp_*, reg_*_out)
//   slave modport  : the environment (client + ring tail)
interface reg_ring_master_if
   import reg_ring_pkg::*;
#(
   parameter int ADDR_WIDTH = UDP_REG_ADDR_WIDTH,
   parameter int DATA_WIDTH = CPCI_NF2_DATA_WIDTH,
   parameter int SRC_WIDTH  = 2
);

   logic                  cmd_valid;
   logic                  cmd_ready;
   logic                  cmd_rd_wr_L;
   logic [ADDR_WIDTH-1:0] cmd_addr;
   logic [DATA_WIDTH-1:0] cmd_wdata;

   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [DATA_WIDTH-1:0] rsp_rdata;
   logic [1:0]            rsp_status;

   logic                  reg_req_out;
   logic                  reg_ack_out;
   logic                  reg_rd_wr_L_out;
   logic [ADDR_WIDTH-1:0] reg_addr_out;
   logic [DATA_WIDTH-1:0] reg_data_out;
   logic [SRC_WIDTH-1:0]  reg_src_out;

   logic                  reg_req_in;
   logic                  reg_ack_in;
   logic                  reg_rd_wr_L_in;
   logic [ADDR_WIDTH-1:0] reg_addr_in;
   logic [DATA_WIDTH-1:0] reg_data_in;
   logic [SRC_WIDTH-1:0]  reg_src_in;

   modport master (
      input  cmd_valid, cmd_rd_wr_L, cmd_addr, cmd_wdata, rsp_ready,
      input  reg_req_in, reg_ack_in, reg_rd_wr_L_in, reg_addr_in, reg_data_in, reg_src_in,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_status,
      output reg_req_out, reg_ack_out, reg_rd_wr_L_out, reg_addr_out, reg_data_out, reg_src_out
   );

   modport slave (
      output cmd_valid, cmd_rd_wr_L, cmd_addr, cmd_wdata, rsp_ready,
      output reg_req_in, reg_ack_in, reg_rd_wr_L_in, reg_addr_in, reg_data_in, reg_src_in,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_status,
      input  reg_req_out, reg_ack_out, reg_rd_wr_L_out, reg_addr_out, reg_data_out, reg_src_out
   );

endinterface

// File: rtl/reg_ring_master.sv
// Head-of-ring initiator: turns single client register commands into ring
// transactions, waits for the request to come back round the ring and hands
// read data plus completion status back on a valid/ready response port.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   bus        : reg_ring_master_if.master (client cmd/rsp + ring in/out)
//   stray_cnt  : saturating count of discarded unexpected returns
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | cmd_ready high, waiting for a client command
// ST_ISSUE | single-cycle request pulse on the ring
// ST_WAIT  | waiting for our request to return, or the timeout to expire
// ST_RESP  | rsp_valid high, holding the response until the client takes it
module reg_ring_master
   import reg_ring_pkg::*;
#(
   parameter int                           ADDR_WIDTH        = UDP_REG_ADDR_WIDTH,
   parameter int                           DATA_WIDTH        = CPCI_NF2_DATA_WIDTH,
   parameter int                           UDP_REG_SRC_WIDTH = 2,
   parameter logic [UDP_REG_SRC_WIDTH-1:0] SRC_ID            = 2'd3,
   parameter int                           TIMEOUT_CYCLES    = 1024
) (
   input  logic               clk,
   input  logic               reset,
   reg_ring_master_if.master  bus,
   output logic [7:0]         stray_cnt
);

   localparam int TMR_W = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

   state_t             state;
   logic [TMR_W-1:0]   tmr;
   logic               ret_match;
   logic               stray;

   assign ret_match = bus.reg_req_in && (bus.reg_src_in == SRC_ID);
   // Anything on the ring that is not the return we are waiting for.
   assign stray     = bus.reg_req_in && (!ret_match || state != ST_WAIT);

   always_ff @(posedge clk) begin
      if (reset) begin
         state               <= ST_IDLE;
         tmr                 <= '0;
         stray_cnt           <= '0;
         bus.cmd_ready       <= 1'b1;
         bus.rsp_valid       <= 1'b0;
         bus.rsp_rdata       <= '0;
         bus.rsp_status      <= RSP_OK;
         bus.reg_req_out     <= 1'b0;
         bus.reg_ack_out     <= 1'b0;
         bus.reg_rd_wr_L_out <= 1'b0;
         bus.reg_addr_out    <= '0;
         bus.reg_data_out    <= '0;
         bus.reg_src_out     <= '0;
      end else begin
         if (stray && stray_cnt != 8'hFF)
            stray_cnt <= stray_cnt + 8'd1;

         case (state)
            ST_IDLE: begin
               // Ring outputs are loaded straight from the handshake so the
               // request appears in the cycle right after acceptance.
               if (bus.cmd_valid) begin
                  bus.cmd_ready       <= 1'b0;
                  bus.reg_req_out     <= 1'b1;
                  bus.reg_ack_out     <= 1'b0;
                  bus.reg_rd_wr_L_out <= bus.cmd_rd_wr_L;
                  bus.reg_addr_out    <= bus.cmd_addr;
                  bus.reg_data_out    <= bus.cmd_rd_wr_L ? '0 : bus.cmd_wdata;
                  bus.reg_src_out     <= SRC_ID;
                  tmr                 <= '0;
                  state               <= ST_ISSUE;
               end
            end

            ST_ISSUE: begin
               // tmr counts cycles since the issue cycle, so the timeout
               // lands TIMEOUT_CYCLES cycles after the request pulse.
               bus.reg_req_out     <= 1'b0;
               bus.reg_rd_wr_L_out <= 1'b0;
               bus.reg_addr_out    <= '0;
               bus.reg_data_out    <= '0;
               bus.reg_src_out     <= '0;
               tmr                 <= tmr + 1'b1;
               state               <= ST_WAIT;
            end

            ST_WAIT: begin
               tmr <= tmr + 1'b1;
               if (ret_match) begin
                  bus.rsp_rdata  <= bus.reg_data_in;
                  bus.rsp_status <= bus.reg_ack_in ? RSP_OK : RSP_NACK;
                  bus.rsp_valid  <= 1'b1;
                  state          <= ST_RESP;
               end else if (tmr == TMR_LAST) begin
                  bus.rsp_rdata  <= '0;
                  bus.rsp_status <= RSP_TIMEOUT;
                  bus.rsp_valid  <= 1'b1;
                  state          <= ST_RESP;
               end
            end

            ST_RESP: begin
               if (bus.rsp_ready) begin
                  bus.rsp_valid <= 1'b0;
                  bus.cmd_ready <= 1'b1;
                  state         <= ST_IDLE;
               end
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_reg_ring_master.sv
// Directed bench for reg_ring_master: write/read hits, NACK, timeout with a
// late return, backpressure with a foreign return, and reset mid-WAIT.
module tb_reg_ring_master;
   import reg_ring_pkg::*;

   localparam int AW = 23;
   localparam int DW = 32;
   localparam int SW = 2;

   logic       clk;
   logic       reset;
   logic [7:0] stray_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   reg_ring_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SRC_WIDTH(SW)) bus ();

   reg_ring_master #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .UDP_REG_SRC_WIDTH(SW),
      .SRC_ID(2'd3), .TIMEOUT_CYCLES(16)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus.master),
      .stray_cnt (stray_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic nedge();
      @(negedge clk);
   endtask

   task automatic send_cmd(input logic rd, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
      bus.cmd_valid   = 1'b1;
      bus.cmd_rd_wr_L = rd;
      bus.cmd_addr    = addr;
      bus.cmd_wdata   = wdata;
   endtask

   task automatic ring_ret(input logic ack, input logic [SW-1:0] src, input logic [DW-1:0] data);
      bus.reg_req_in     = 1'b1;
      bus.reg_ack_in     = ack;
      bus.reg_src_in     = src;
      bus.reg_data_in    = data;
      bus.reg_rd_wr_L_in = 1'b0;
      bus.reg_addr_in    = '0;
   endtask

   task automatic ring_idle();
      bus.reg_req_in  = 1'b0;
      bus.reg_ack_in  = 1'b0;
      bus.reg_src_in  = '0;
      bus.reg_data_in = '0;
   endtask

   initial begin
      reset = 1'b1;
      bus.cmd_valid = 1'b0; bus.cmd_rd_wr_L = 1'b0; bus.cmd_addr = '0; bus.cmd_wdata = '0;
      bus.rsp_ready = 1'b0;
      bus.reg_rd_wr_L_in = 1'b0; bus.reg_addr_in = '0;
      ring_idle();
      nedge(); nedge();

      // reset state
      chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
      chk("rst_rsp_status", 32'(bus.rsp_status), 32'd0);
      chk("rst_req_out", 32'(bus.reg_req_out), 32'd0);
      chk("rst_addr_out", 32'(bus.reg_addr_out), 32'd0);
      chk("rst_stray", 32'(stray_cnt), 32'd0);
      reset = 1'b0;
      nedge();

      // write hit
      send_cmd(1'b0, 23'h000101, 32'hDEADBEEF);
      nedge();
      bus.cmd_valid = 1'b0;
      chk("wr_cmd_ready_low", 32'(bus.cmd_ready), 32'd0);
      chk("wr_req_out", 32'(bus.reg_req_out), 32'd1);
      chk("wr_ack_out", 32'(bus.reg_ack_out), 32'd0);
      chk("wr_rdwr_out", 32'(bus.reg_rd_wr_L_out), 32'd0);
      chk("wr_addr_out", 32'(bus.reg_addr_out), 32'h000101);
      chk("wr_data_out", bus.reg_data_out, 32'hDEADBEEF);
      chk("wr_src_out", 32'(bus.reg_src_out), 32'd3);
      nedge();
      chk("wr_req_pulse_end", 32'(bus.reg_req_out), 32'd0);
      chk("wr_data_out_clr", bus.reg_data_out, 32'd0);
      chk("wr_cmd_ready_wait", 32'(bus.cmd_ready), 32'd0);
      nedge();
      ring_ret(1'b1, 2'd3, 32'hDEADBEEF);
      nedge();
      ring_idle();
      chk("wr_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("wr_rsp_status", 32'(bus.rsp_status), 32'(RSP_OK));
      chk("wr_rsp_rdata", bus.rsp_rdata, 32'hDEADBEEF);
      chk("wr_cmd_ready_resp", 32'(bus.cmd_ready), 32'd0);
      bus.rsp_ready = 1'b1;
      nedge();
      chk("wr_rsp_done", 32'(bus.rsp_valid), 32'd0);
      chk("wr_cmd_ready_back", 32'(bus.cmd_ready), 32'd1);

      // read hit, rsp_ready already high on RESP entry
      send_cmd(1'b1, 23'h000100, 32'h12345678);
      nedge();
      bus.cmd_valid = 1'b0;
      chk("rd_req_out", 32'(bus.reg_req_out), 32'd1);
      chk("rd_rdwr_out", 32'(bus.reg_rd_wr_L_out), 32'd1);
      chk("rd_addr_out", 32'(bus.reg_addr_out), 32'h000100);
      chk("rd_data_out_zero", bus.reg_data_out, 32'd0);
      nedge();
      ring_ret(1'b1, 2'd3, 32'h000001A5);
      nedge();
      ring_idle();
      chk("rd_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("rd_rsp_rdata", bus.rsp_rdata, 32'h000001A5);
      chk("rd_rsp_status", 32'(bus.rsp_status), 32'(RSP_OK));
      nedge();
      chk("rd_rsp_one_cycle", 32'(bus.rsp_valid), 32'd0);
      chk("rd_cmd_ready_back", 32'(bus.cmd_ready), 32'd1);

      // NACK: request comes back unchanged
      send_cmd(1'b0, 23'h000055, 32'h0BADF00D);
      nedge();
      bus.cmd_valid = 1'b0;
      nedge();
      ring_ret(1'b0, 2'd3, 32'h0BADF00D);
      nedge();
      ring_idle();
      chk("nack_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("nack_rsp_status", 32'(bus.rsp_status), 32'(RSP_NACK));
      chk("nack_rsp_rdata", bus.rsp_rdata, 32'h0BADF00D);
      nedge();
      chk("nack_done", 32'(bus.rsp_valid), 32'd0);

      // timeout: response exactly 16 cycles after the issue cycle
      bus.rsp_ready = 1'b0;
      send_cmd(1'b1, 23'h000200, 32'h0);
      nedge();
      bus.cmd_valid = 1'b0;
      chk("to_req_out", 32'(bus.reg_req_out), 32'd1);
      for (int k = 1; k < 16; k++) begin
         nedge();
         chk($sformatf("to_no_rsp_%0d", k), 32'(bus.rsp_valid), 32'd0);
      end
      nedge();
      chk("to_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("to_rsp_status", 32'(bus.rsp_status), 32'(RSP_TIMEOUT));
      chk("to_rsp_rdata", bus.rsp_rdata, 32'd0);
      bus.rsp_ready = 1'b1;
      nedge();
      chk("to_done", 32'(bus.rsp_valid), 32'd0);
      for (int k = 0; k < 4; k++) nedge();
      ring_ret(1'b1, 2'd3, 32'hCAFE0001);
      nedge();
      ring_idle();
      chk("late_stray_cnt", 32'(stray_cnt), 32'd1);
      chk("late_no_rsp", 32'(bus.rsp_valid), 32'd0);
      chk("late_cmd_ready", 32'(bus.cmd_ready), 32'd1);
      nedge();
      chk("late_no_rsp2", 32'(bus.rsp_valid), 32'd0);

      // backpressure and foreign source during WAIT
      bus.rsp_ready = 1'b0;
      send_cmd(1'b0, 23'h000300, 32'h11112222);
      nedge();
      bus.cmd_valid = 1'b0;
      nedge();
      ring_ret(1'b1, 2'd1, 32'hBAD0BAD0);
      nedge();
      chk("fgn_not_done", 32'(bus.rsp_valid), 32'd0);
      chk("fgn_stray_cnt", 32'(stray_cnt), 32'd2);
      ring_ret(1'b1, 2'd3, 32'h33334444);
      nedge();
      ring_idle();
      chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("bp_rsp_rdata", bus.rsp_rdata, 32'h33334444);
      send_cmd(1'b1, 23'h000777, 32'h0);
      for (int k = 0; k < 10; k++) begin
         nedge();
         chk($sformatf("bp_hold_valid_%0d", k), 32'(bus.rsp_valid), 32'd1);
         chk($sformatf("bp_hold_rdata_%0d", k), bus.rsp_rdata, 32'h33334444);
         chk($sformatf("bp_hold_status_%0d", k), 32'(bus.rsp_status), 32'(RSP_OK));
         chk($sformatf("bp_no_accept_%0d", k), 32'(bus.reg_req_out), 32'd0);
      end
      bus.cmd_valid = 1'b0;
      bus.rsp_ready = 1'b1;
      nedge();
      chk("bp_done", 32'(bus.rsp_valid), 32'd0);
      chk("bp_cmd_ready", 32'(bus.cmd_ready), 32'd1);
      chk("bp_stray_kept", 32'(stray_cnt), 32'd2);
      bus.rsp_ready = 1'b0;

      // reset in the middle of WAIT
      send_cmd(1'b1, 23'h000400, 32'h0);
      nedge();
      bus.cmd_valid = 1'b0;
      nedge();
      reset = 1'b1;
      nedge();
      reset = 1'b0;
      chk("mrst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
      chk("mrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("mrst_rsp_rdata", bus.rsp_rdata, 32'd0);
      chk("mrst_stray", 32'(stray_cnt), 32'd0);
      chk("mrst_req_out", 32'(bus.reg_req_out), 32'd0);
      nedge();
      ring_ret(1'b1, 2'd3, 32'h00000400);
      nedge();
      ring_idle();
      chk("mrst_late_stray", 32'(stray_cnt), 32'd1);
      chk("mrst_late_no_rsp", 32'(bus.rsp_valid), 32'd0);
      nedge();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
